ising_spin_updater: RTL

Sequencer and spin-update stage wrapped around the dot-product engine. For each spin index it issues one dot-product request, receives the local field h_i = Σ_j (σ_j ? +J_ij : −J_ij), and decides whether to flip σ_i. It updates the spin vector and the running energy after each decision, and repeats for a programmed number of sweeps. It owns the σ register that feeds the engine's sign-vector input and drives the J-column address.

---
 rtl/ising_pkg.sv | 21 ++
 rtl/ising_spin_updater_if.sv | 28 ++
 rtl/ising_lfsr16.sv | 26 ++
 rtl/ising_spin_updater.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/ising_pkg.sv
// Shared definitions for the Ising spin updater: FSM state encoding,
// accumulator width helper and spin encoding constants.
package ising_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE  = 3'd1,
    WAIT   = 3'd2,
    UPDATE = 3'd3,
    FINISH = 3'd4
  } state_t;

  localparam logic SPIN_POS = 1'b1;
  localparam logic SPIN_NEG = 1'b0;

  // Dot-product accumulator width for n-bit J elements over vw spins.
  function automatic int acc_width(input int n, input int vw);
    return n + 2 * $clog2(vw);
  endfunction

endpackage

// File: rtl/ising_spin_updater_if.sv
// Request/response channel between the spin updater (master) and the
// dot-product engine (slave).
interface ising_spin_updater_if
  import ising_pkg::*;
#(
  parameter int VECTOR_WIDTH = 256,
  parameter int N            = 8,
  parameter int ACC_WIDTH    = acc_width(N, VECTOR_WIDTH)
);
  localparam int IDX_W = $clog2(VECTOR_WIDTH);

  logic                    mm_start;
  logic [IDX_W-1:0]        mm_col_idx;
  logic [ACC_WIDTH:0]      mm_e_p;
  logic signed [ACC_WIDTH:0] mm_dot_result;
  logic                    mm_done;
  logic                    mm_flag;

  modport master (
    output mm_start, mm_col_idx, mm_e_p,
    input  mm_dot_result, mm_done, mm_flag
  );

  modport slave (
    input  mm_start, mm_col_idx, mm_e_p,
    output mm_dot_result, mm_done, mm_flag
  );
endinterface

// File: rtl/ising_lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded with 0xACE1 on reset and
// on seed_load; advances one position per step.
module ising_lfsr16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic        seed_load,
  output logic [15:0] value
);
  localparam logic [15:0] SEED = 16'hACE1;

  logic [15:0] lfsr_q;

  // Shift register with reseed taking priority over stepping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else if (seed_load) begin
      lfsr_q <= SEED;
    end else if (step) begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign value = lfsr_q;
endmodule

// File: rtl/ising_spin_updater.sv
// Sequencer and spin-update stage around the dot-product engine: walks every
// spin index for num_sweeps sweeps, requests the local field, and flips the
// spin when that lowers the energy. Optional feature macro:
// SPIN_UPDATE_ANNEAL_EN enables LFSR-driven acceptance of uphill flips.
module ising_spin_updater
  import ising_pkg::*;
#(
  parameter int VECTOR_WIDTH = 256,
  parameter int N            = 8,
  parameter int ACC_WIDTH    = acc_width(N, VECTOR_WIDTH),
  parameter int SWEEP_W      = 16
)(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      run,
  input  logic [SWEEP_W-1:0]        num_sweeps,
  input  logic [VECTOR_WIDTH-1:0]   sigma_init,
  input  logic signed [ACC_WIDTH+1:0] energy_init,
  input  logic [7:0]                accept_thr,
  ising_spin_updater_if.master      mm,
  output logic [VECTOR_WIDTH-1:0]   sigma,
  output logic signed [ACC_WIDTH+1:0] energy,
  output logic                      busy,
  output logic                      sweep_done,
  output logic [15:0]               abort_count
);
  localparam int IDX_W = $clog2(VECTOR_WIDTH);
  localparam int RW    = ACC_WIDTH + 1;
  localparam int EW    = ACC_WIDTH + 2;
  localparam int DW    = ACC_WIDTH + 3;

  state_t                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic [SWEEP_W-1:0]       sweep_q, sweep_d;
  logic [SWEEP_W-1:0]       sweeps_q, sweeps_d;
  logic [VECTOR_WIDTH-1:0]  sigma_q, sigma_d;
  logic signed [EW-1:0]     energy_q, energy_d;
  logic [15:0]              abort_q, abort_d;
  logic signed [RW-1:0]     h_q;
  logic                     flag_q;
  logic signed [DW-1:0]     delta;
  logic                     flip;
  logic                     uphill_ok;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Energy change for flipping a spin of value s in local field h.
  function automatic logic signed [DW-1:0] spin_delta(input logic s,
                                                      input logic signed [RW-1:0] h);
    logic signed [DW-1:0] two_h;
    two_h = {{(DW - RW){h[RW-1]}}, h} << 1;
    return (s == SPIN_POS) ? -two_h : two_h;
  endfunction

`ifdef SPIN_UPDATE_ANNEAL_EN
  logic [15:0] lfsr_val;
  logic        lfsr_step;
  logic        lfsr_seed;

  assign lfsr_step = (state_q == UPDATE);
  assign lfsr_seed = (state_q == IDLE) && run;

  ising_lfsr16 u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .step      (lfsr_step),
    .seed_load (lfsr_seed),
    .value     (lfsr_val)
  );

  assign uphill_ok = (lfsr_val[7:0] < accept_thr);
`else
  logic unused_accept_thr;
  assign unused_accept_thr = ^accept_thr;
  assign uphill_ok = 1'b0;
`endif

  // Next-state logic: FSM transitions plus spin/energy/counter updates.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    sweep_d  = sweep_q;
    sweeps_d = sweeps_q;
    sigma_d  = sigma_q;
    energy_d = energy_q;
    abort_d  = abort_q;
    delta    = spin_delta(sigma_q[idx_q], h_q);
    flip     = 1'b0;
    case (state_q)
      IDLE: begin
        if (run) begin
          sigma_d  = sigma_init;
          energy_d = energy_init;
          idx_d    = '0;
          sweep_d  = '0;
          abort_d  = '0;
          sweeps_d = (num_sweeps == '0) ? SWEEP_W'(1) : num_sweeps;
          state_d  = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mm.mm_done) state_d = UPDATE;
      end
      UPDATE: begin
        // A flagged result is partial, so it never drives a flip.
        if (flag_q) begin
          abort_d = sat_inc16(abort_q);
        end else begin
          flip = (delta < 0) || ((delta > 0) && uphill_ok);
        end
        if (flip) begin
          sigma_d[idx_q] = ~sigma_q[idx_q];
          energy_d       = energy_q + $signed(delta[EW-1:0]);
        end
        if (idx_q == IDX_W'(VECTOR_WIDTH - 1)) begin
          idx_d   = '0;
          sweep_d = sweep_q + SWEEP_W'(1);
          state_d = (sweep_q == sweeps_q - SWEEP_W'(1)) ? FINISH : ISSUE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = ISSUE;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control and architectural state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      sweep_q  <= '0;
      sweeps_q <= SWEEP_W'(1);
      sigma_q  <= {VECTOR_WIDTH{SPIN_NEG}};
      energy_q <= '0;
      abort_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      sweep_q  <= sweep_d;
      sweeps_q <= sweeps_d;
      sigma_q  <= sigma_d;
      energy_q <= energy_d;
      abort_q  <= abort_d;
    end
  end

  // Engine response capture; only a result arriving in WAIT is taken.
  always_ff @(posedge clk) begin
    if ((state_q == WAIT) && mm.mm_done) begin
      h_q    <= mm.mm_dot_result;
      flag_q <= mm.mm_flag;
    end
  end

  assign mm.mm_start   = (state_q == ISSUE);
  assign mm.mm_col_idx = idx_q;
  assign mm.mm_e_p     = {1'b0, {ACC_WIDTH{1'b1}}};
  assign sigma         = sigma_q;
  assign energy        = energy_q;
  assign busy          = (state_q != IDLE);
  assign sweep_done    = (state_q == FINISH);
  assign abort_count   = abort_q;
endmodule
